// File: rtl/fir_sequencer.sv
// Control front-end for the adaptive-coefficient FIR: setup hold-off, coefficient
// collection and back-to-back push, then gap-free sample streaming from a small FIFO.
module fir_sequencer #(
    parameter int unsigned X_N_SIZE     = 8,
    parameter int unsigned TAP_SIZE     = 6,
    parameter int unsigned NBR_OF_TAPS  = 3,
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned IDLE_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TAP_SIZE-1:0] coef_in,
    input  logic                coef_valid,
    output logic                coef_ready,
    input  logic [X_N_SIZE-1:0] smp_in,
    input  logic                smp_valid,
    output logic                smp_ready,
    output logic [X_N_SIZE-1:0] fir_x_n,
    output logic                fir_tvalid,
    output logic                fir_set_coeffs,
    output logic                coeffs_loaded,
    output logic                busy
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned M1  = (SETUP_CYCLES > GUARD_CYCLES) ? SETUP_CYCLES : GUARD_CYCLES;
    localparam int unsigned M2  = (M1 > NBR_OF_TAPS) ? M1 : NBR_OF_TAPS;
    localparam int unsigned CW  = $clog2(M2 + 1);
    localparam int unsigned IW  = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned TW  = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {INIT, IDLE, COLLECT, PUSH, GUARD, STREAM, DRAIN} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idle_cnt;
    logic [TAP_SIZE-1:0] slots [NBR_OF_TAPS];
    logic [X_N_SIZE-1:0] mem   [FIFO_DEPTH];
    logic [AW:0]         wptr, rptr, wptr_q;
    logic                full, empty, push, pop, timed_out;
    logic [TW-1:0]       tap_idx;

    // Emptiness is judged against a one-cycle-old copy of the write pointer, so a fresh
    // entry only becomes poppable on the second edge after it was written.
    always_comb begin
        full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        empty      = (rptr == wptr_q);
        timed_out  = (idle_cnt == IW'(IDLE_TIMEOUT));
        coef_ready = (state == IDLE) || (state == COLLECT);
        smp_ready  = (((state == IDLE) && coeffs_loaded) || (state == STREAM))
                     && !full && !coef_valid;
        busy       = (state != IDLE);
        push       = smp_valid && smp_ready;
        pop        = !empty && (((state == STREAM) && !timed_out) || (state == DRAIN));
        tap_idx    = cnt[TW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            wptr_q <= '0;
        end else begin
            wptr_q <= wptr;
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= smp_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            cnt            <= '0;
            idle_cnt       <= '0;
            fir_x_n        <= '0;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
            coeffs_loaded  <= 1'b0;
            for (int unsigned i = 0; i < NBR_OF_TAPS; i++) slots[i] <= '0;
        end else begin
            fir_x_n        <= '0;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
            case (state)
                INIT: begin
                    if (cnt == CW'(SETUP_CYCLES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else cnt <= cnt + CNT_ONE;
                end
                IDLE: begin
                    idle_cnt <= '0;
                    if (coef_valid) begin
                        slots[0] <= coef_in;
                        if (NBR_OF_TAPS == 1) begin
                            state <= PUSH;
                            cnt   <= '0;
                        end else begin
                            state <= COLLECT;
                            cnt   <= CNT_ONE;
                        end
                    end else if (coeffs_loaded && !empty) state <= STREAM;
                end
                COLLECT: begin
                    if (coef_valid) begin
                        slots[tap_idx] <= coef_in;
                        if (cnt == CW'(NBR_OF_TAPS - 1)) begin
                            state <= PUSH;
                            cnt   <= '0;
                        end else cnt <= cnt + CNT_ONE;
                    end
                end
                PUSH: begin
                    fir_set_coeffs <= 1'b1;
                    fir_x_n        <= X_N_SIZE'($signed(slots[tap_idx]));
                    if (cnt == CW'(NBR_OF_TAPS - 1)) begin
                        state <= GUARD;
                        cnt   <= '0;
                    end else cnt <= cnt + CNT_ONE;
                end
                GUARD: begin
                    if (cnt == CW'(GUARD_CYCLES - 1)) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        coeffs_loaded <= 1'b1;
                    end else cnt <= cnt + CNT_ONE;
                end
                STREAM: begin
                    if (timed_out) state <= IDLE;
                    else begin
                        fir_tvalid <= 1'b1;
                        if (pop) begin
                            fir_x_n  <= mem[rptr[AW-1:0]];
                            idle_cnt <= '0;
                        end else idle_cnt <= idle_cnt + IDLE_ONE;
                        if (coef_valid) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        fir_tvalid <= 1'b1;
                        fir_x_n    <= mem[rptr[AW-1:0]];
                    end else state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
